// File: rtl/fir_seq_ctrl.sv
// FIR sample sequencer: walks a sample ROM, strobes the delay line and the
// MAC datapath once per tap, and toggles between moving-average and FIR
// coefficient banks on a debounced pushbutton press. A mode change is only
// applied between samples, through a one-cycle FLUSH that clears the
// delay line and restarts the frame at address 0.
module fir_seq_ctrl #(
  parameter int TAPS     = 8,
  parameter int ADDR_W   = 5,
  parameter int DEBOUNCE = 4
) (
  input  logic                                   CLOCK_50,
  input  logic                                   reset_n,
  input  logic                                   toggleBtn,
  input  logic                                   run,
  output logic [ADDR_W-1:0]                      sample_addr,
  output logic                                   shift_en,
  output logic                                   dline_clr,
  output logic [((TAPS > 1) ? $clog2(TAPS) : 1)-1:0] tap_idx,
  output logic                                   mac_clr,
  output logic                                   mac_en,
  output logic                                   coef_sel,
  output logic                                   out_valid,
  output logic                                   frame_done,
  output logic                                   LEDG
);

  localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_MAC   = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;
  localparam logic [2:0] S_FLUSH = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TAP_W-1:0]  tap_q, tap_d;
  logic              coef_q, coef_d;
  logic              pending_q, pending_d;

  logic              shift_en_q, dline_clr_q, mac_clr_q, mac_en_q;
  logic              out_valid_q, frame_done_q;

  logic              sync1_q, sync2_q;
  logic              db_level_q;
  logic [CNT_W-1:0]  db_cnt_q;

  logic              db_diff, db_accept, press;

  // The debouncer accepts the synchronized level once it has differed from
  // the accepted level for DEBOUNCE consecutive samples; a press is an
  // accepted high-to-low change, so a release must be accepted first.
  assign db_diff   = (sync2_q != db_level_q);
  assign db_accept = db_diff && (db_cnt_q == CNT_W'(DEBOUNCE - 1));
  assign press     = db_accept && !sync2_q;

  // Two-flop synchronizer and debounce counter for the pushbutton.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      // NOTE: the button idles high, so reset loads the released level;
      // resetting to 0 would fake a press as soon as reset is released.
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      db_level_q <= 1'b1;
      db_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments let sync2_q take the old sync1_q
      // value; blocking ones would collapse the two flops into one.
      sync1_q <= toggleBtn;
      sync2_q <= sync1_q;
      if (!db_diff) begin
        db_cnt_q <= '0;
      end else if (db_accept) begin
        db_level_q <= sync2_q;
        db_cnt_q   <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + CNT_W'(1);
      end
    end
  end

  // Next-state logic for the sequencer, address, tap counter and mode.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    tap_d     = '0;
    coef_d    = coef_q;
    pending_d = pending_q || press;

    case (state_q)
      S_IDLE: begin
        if (pending_q)  state_d = S_FLUSH;
        else if (run)   state_d = S_ADDR;
      end
      S_ADDR:  state_d = S_WAIT;
      S_WAIT:  state_d = S_SHIFT;
      S_SHIFT: state_d = S_MAC;
      S_MAC: begin
        if (tap_q == TAP_W'(TAPS - 1)) state_d = S_OUT;
        else                           tap_d   = tap_q + TAP_W'(1);
      end
      S_OUT: begin
        addr_d = addr_q + ADDR_W'(1);
        if (pending_q)  state_d = S_FLUSH;
        else if (run)   state_d = S_ADDR;
        else            state_d = S_IDLE;
      end
      S_FLUSH: begin
        addr_d    = '0;
        pending_d = 1'b0;
        state_d   = run ? S_ADDR : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The bank flips on entry to FLUSH so it is already visible there.
    if (state_d == S_FLUSH) coef_d = ~coef_q;
  end

  // State, counters and registered strobes decoded from the next state so
  // each strobe lines up with the state that owns it.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      tap_q        <= '0;
      coef_q       <= 1'b0;
      pending_q    <= 1'b0;
      shift_en_q   <= 1'b0;
      dline_clr_q  <= 1'b0;
      mac_clr_q    <= 1'b0;
      mac_en_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      tap_q        <= tap_d;
      coef_q       <= coef_d;
      pending_q    <= pending_d;
      shift_en_q   <= (state_d == S_SHIFT);
      dline_clr_q  <= (state_d == S_FLUSH);
      mac_en_q     <= (state_d == S_MAC);
      mac_clr_q    <= (state_d == S_MAC) && (tap_d == '0);
      out_valid_q  <= (state_d == S_OUT);
      frame_done_q <= (state_d == S_OUT) && (addr_d == '1);
    end
  end

  assign sample_addr = addr_q;
  assign tap_idx     = tap_q;
  assign coef_sel    = coef_q;
  assign LEDG        = coef_q;
  assign shift_en    = shift_en_q;
  assign dline_clr   = dline_clr_q;
  assign mac_clr     = mac_clr_q;
  assign mac_en      = mac_en_q;
  assign out_valid   = out_valid_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl with default parameters (TAPS=8,
// ADDR_W=5, DEBOUNCE=4). One sample spans 12 cycles: ADDR, WAIT, SHIFT,
// eight MAC cycles, OUT. Outputs are sampled on the falling edge.
module tb_fir_seq_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n;
  logic       toggleBtn;
  logic       run;
  logic [4:0] sample_addr;
  logic       shift_en, dline_clr, mac_clr, mac_en;
  logic [2:0] tap_idx;
  logic       coef_sel, out_valid, frame_done, LEDG;

  int checks = 0;
  int errors = 0;

  fir_seq_ctrl dut (
    .CLOCK_50   (CLOCK_50),
    .reset_n    (reset_n),
    .toggleBtn  (toggleBtn),
    .run        (run),
    .sample_addr(sample_addr),
    .shift_en   (shift_en),
    .dline_clr  (dline_clr),
    .tap_idx    (tap_idx),
    .mac_clr    (mac_clr),
    .mac_en     (mac_en),
    .coef_sel   (coef_sel),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .LEDG       (LEDG)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {shift_en, dline_clr, mac_clr, mac_en, out_valid, frame_done, coef_sel, LEDG}
  function automatic logic [7:0] obs();
    return {shift_en, dline_clr, mac_clr, mac_en, out_valid, frame_done,
            coef_sel, LEDG};
  endfunction

  // Expected strobe vector at cycle offset o of a sample (o=0 is ADDR).
  function automatic logic [7:0] exp_vec(input int o, input bit last,
                                         input bit coef);
    logic [7:0] v;
    v[7] = (o == 2);
    v[6] = 1'b0;
    v[5] = (o == 3);
    v[4] = (o >= 3) && (o <= 10);
    v[3] = (o == 11);
    v[2] = (o == 11) && last;
    v[1] = coef;
    v[0] = coef;
    return v;
  endfunction

  // Called at the falling edge where the DUT sits in ADDR; returns at the
  // falling edge after OUT has been left.
  task automatic do_sample(input int addr, input bit coef);
    for (int o = 0; o < 12; o++) begin
      check($sformatf("strobes a%0d o%0d", addr, o), 32'(obs()),
            32'(exp_vec(o, addr == 31, coef)));
      if (o == 0) check($sformatf("addr a%0d", addr), 32'(sample_addr), 32'(addr));
      if (o >= 3 && o <= 10)
        check($sformatf("tap a%0d o%0d", addr, o), 32'(tap_idx), 32'(o - 3));
      @(negedge CLOCK_50);
    end
  endtask

  // Hold the button low for n cycles, then release it.
  task automatic hold_btn(input int n);
    toggleBtn = 1'b0;
    repeat (n) @(negedge CLOCK_50);
    toggleBtn = 1'b1;
  endtask

  // Wait (bounded) for a FLUSH cycle in IDLE and check its outputs.
  task automatic wait_flush(input bit coef);
    bit found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLOCK_50);
      if (dline_clr) begin
        found = 1'b1;
        break;
      end
    end
    check("flush seen", 32'(found), 32'd1);
    check("flush strobes", 32'(obs()), 32'({6'b010000, coef, coef}));
    @(negedge CLOCK_50);
    check("post flush strobes", 32'(obs()), 32'({6'b000000, coef, coef}));
    check("post flush addr", 32'(sample_addr), 32'd0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    toggleBtn = 1'b1;
    run       = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("reset strobes", 32'(obs()), 32'd0);
    check("reset addr", 32'(sample_addr), 32'd0);
    check("reset tap", 32'(tap_idx), 32'd0);

    // Continuous run: a full frame of 32 samples, then the wrap to 0.
    reset_n = 1'b1;
    run     = 1'b1;
    @(negedge CLOCK_50);
    for (int i = 0; i < 33; i++) do_sample(i % 32, 1'b0);

    // Press held 6 cycles during MAC of sample 1: finishes, then FLUSH.
    fork
      do_sample(1, 1'b0);
      begin
        repeat (4) @(negedge CLOCK_50);
        hold_btn(6);
      end
    join
    check("flush strobes run", 32'(obs()), 32'b01000011);
    @(negedge CLOCK_50);
    do_sample(0, 1'b1);

    // Two-cycle glitch: ignored, no FLUSH before the next sample.
    fork
      do_sample(1, 1'b1);
      begin
        repeat (4) @(negedge CLOCK_50);
        hold_btn(2);
      end
    join
    do_sample(2, 1'b1);

    // Reset pulse mid-MAC at tap 3 of sample 3.
    repeat (6) @(negedge CLOCK_50);
    check("tap before reset", 32'(tap_idx), 32'd3);
    check("mac_en before reset", 32'(mac_en), 32'd1);
    reset_n = 1'b0;
    @(negedge CLOCK_50);
    check("mid-mac reset strobes", 32'(obs()), 32'd0);
    check("mid-mac reset addr", 32'(sample_addr), 32'd0);
    check("mid-mac reset tap", 32'(tap_idx), 32'd0);
    reset_n = 1'b1;
    @(negedge CLOCK_50);
    do_sample(0, 1'b0);

    // run dropped during WAIT: sample completes, then IDLE at addr 2.
    fork
      do_sample(1, 1'b0);
      begin
        @(negedge CLOCK_50);
        run = 1'b0;
      end
    join
    for (int i = 0; i < 3; i++) begin
      check($sformatf("idle strobes %0d", i), 32'(obs()), 32'd0);
      check($sformatf("idle addr %0d", i), 32'(sample_addr), 32'd2);
      @(negedge CLOCK_50);
    end

    // Two held presses with a release between, from IDLE: 0 -> 1 -> 0.
    fork
      hold_btn(6);
      wait_flush(1'b1);
    join
    repeat (8) @(negedge CLOCK_50);
    fork
      hold_btn(6);
      wait_flush(1'b0);
    join
    repeat (4) @(negedge CLOCK_50);
    check("final idle strobes", 32'(obs()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
